imm_ext_q: RTL and testbench

//  Parametrised, buffered successor to the decode-stage immediate extender. Accepts 16-bit WISC

---
 rtl/imm_ext_q.sv | 134 +++++++++++++
 tb/tb_imm_ext_q.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_q.sv
// Immediate extender with a DEPTH-entry output queue: decodes the WISC immediate format of each
// accepted instruction, extends it to DATA_W bits and buffers {fmt, imm} for the execute stage.
module imm_ext_q #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        imm,
  output logic [2:0]               fmt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + 3;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_SE5  = 3'd1,
    FMT_ZE5  = 3'd2,
    FMT_SE8  = 3'd3,
    FMT_ZE8  = 3'd4,
    FMT_SE11 = 3'd5
  } fmt_e;

  typedef enum logic {
    S_EMPTY    = 1'b0,
    S_NONEMPTY = 1'b1
  } state_e;

  logic [4:0]        w_op;
  fmt_e              w_fmt;
  logic [DATA_W-1:0] w_imm;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [EW-1:0]     w_head;
  state_e            w_state_nxt;

  logic [EW-1:0]     r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  state_e            r_state;

  assign w_op = instr[15:11];

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    w_fmt = FMT_NONE;
    casez (w_op)
      5'b01000, 5'b01001, 5'b10100, 5'b10101,
      5'b10000, 5'b10001, 5'b10011:           w_fmt = FMT_SE5;
      5'b01010, 5'b01011:                     w_fmt = FMT_ZE5;
      5'b011??, 5'b11000, 5'b00101, 5'b00111: w_fmt = FMT_SE8;
      5'b10010:                               w_fmt = FMT_ZE8;
      5'b00100, 5'b00110:                     w_fmt = FMT_SE11;
      default:                                w_fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    w_imm = '0;
    case (w_fmt)
      FMT_SE5:  w_imm = {{(DATA_W-5){instr[4]}}, instr[4:0]};
      FMT_ZE5:  w_imm = {{(DATA_W-5){1'b0}}, instr[4:0]};
      FMT_SE8:  w_imm = {{(DATA_W-8){instr[7]}}, instr[7:0]};
      FMT_ZE8:  w_imm = {{(DATA_W-8){1'b0}}, instr[7:0]};
      FMT_SE11: w_imm = {{(DATA_W-11){instr[10]}}, instr[10:0]};
      default:  w_imm = '0;
    endcase
  end

  // in_ready is a function of occupancy only, never of out_ready.
  assign w_full    = (r_count == CW'(DEPTH));
  assign in_ready  = ~w_full;
  assign out_valid = (r_state == S_NONEMPTY);
  assign w_push    = in_valid & ~w_full;
  assign w_pop     = out_valid & out_ready;

  // NOTE: the storage array is deliberately not reset; the output mux below hides stale data.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_push) begin
      r_mem[r_wr_ptr] <= {w_fmt, w_imm};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY:    if (w_push) w_state_nxt = S_NONEMPTY;
      S_NONEMPTY: if (w_pop && !w_push && r_count == CW'(1)) w_state_nxt = S_EMPTY;
      default:    w_state_nxt = S_EMPTY;
    endcase
  end

  assign w_head = r_mem[r_rd_ptr];
  assign imm    = out_valid ? w_head[DATA_W-1:0] : '0;
  assign fmt    = out_valid ? w_head[EW-1 -: 3] : 3'd0;
  assign count  = r_count;

endmodule

// File: tb/tb_imm_ext_q.sv
// Bench for imm_ext_q: a DATA_W=16 and a DATA_W=32 instance share all stimulus and are checked
// against a queue-based reference model of the extender.
module tb_imm_ext_q;

  localparam int D = 2;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [15:0] instr;
  logic        out_ready;

  logic        in_ready16, out_valid16;
  logic [15:0] imm16;
  logic [2:0]  fmt16;
  logic [1:0]  count16;

  logic        in_ready32, out_valid32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [1:0]  count32;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  fmt;
  } ent_t;

  ent_t q[$];

  imm_ext_q #(.DATA_W(16), .DEPTH(D)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready16),
    .instr(instr), .out_valid(out_valid16), .out_ready(out_ready), .imm(imm16), .fmt(fmt16),
    .count(count16)
  );

  imm_ext_q #(.DATA_W(32), .DEPTH(D)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .out_valid(out_valid32), .out_ready(out_ready), .imm(imm32), .fmt(fmt32),
    .count(count32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [22:0] act16 = {in_ready16, out_valid16, count16, fmt16, imm16};
  wire [38:0] act32 = {in_ready32, out_valid32, count32, fmt32, imm32};

  // Reference decode: classify by opcode set, then extend the field arithmetically.
  function automatic ent_t ref_decode(input logic [15:0] w);
    ent_t   e;
    int     op;
    int     width;
    bit     sgn;
    longint v;
    op    = int'(w[15:11]);
    width = 0;
    sgn   = 1'b0;
    e.fmt = 3'd0;
    if (op inside {8, 9, 20, 21, 16, 17, 19})          begin e.fmt = 3'd1; width = 5;  sgn = 1'b1; end
    else if (op inside {10, 11})                       begin e.fmt = 3'd2; width = 5;  sgn = 1'b0; end
    else if (op inside {[12:15], 24, 5, 7})            begin e.fmt = 3'd3; width = 8;  sgn = 1'b1; end
    else if (op == 18)                                 begin e.fmt = 3'd4; width = 8;  sgn = 1'b0; end
    else if (op inside {4, 6})                         begin e.fmt = 3'd5; width = 11; sgn = 1'b1; end
    if (width == 0) begin
      v = 0;
    end else begin
      v = longint'(w) % (longint'(1) << width);
      if (sgn && v >= (longint'(1) << (width - 1))) v = v - (longint'(1) << width);
    end
    e.imm = 32'(v);
    return e;
  endfunction

  function automatic logic [22:0] exp16();
    ent_t h;
    h = (q.size() != 0) ? q[0] : '0;
    return {q.size() < D, q.size() != 0, 2'(q.size()), h.fmt, h.imm[15:0]};
  endfunction

  function automatic logic [38:0] exp32();
    ent_t h;
    h = (q.size() != 0) ? q[0] : '0;
    return {q.size() < D, q.size() != 0, 2'(q.size()), h.fmt, h.imm};
  endfunction

  // Drives one cycle of stimulus, advances past the edge, and updates the model.
  task automatic tick(input logic v, input logic [15:0] w, input logic ordy,
                      input logic fl, input logic rn);
    bit do_push, do_pop;
    in_valid  = v;
    instr     = w;
    out_ready = ordy;
    flush     = fl;
    rst_n     = rn;
    do_push   = v && (q.size() < D);
    do_pop    = ordy && (q.size() > 0);
    @(posedge clk);
    #1;
    if (!rn || fl) begin
      q.delete();
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(ref_decode(w));
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 16'h401F, 1'b0, 1'b0, 1'b0);
    checks++;
    if (act16 !== {1'b1, 1'b0, 2'd0, 3'd0, 16'h0}) begin
      errors++;
      $display("FAIL reset16: got %h expected %h", act16, {1'b1, 1'b0, 2'd0, 3'd0, 16'h0});
    end
    checks++;
    if (act32 !== {1'b1, 1'b0, 2'd0, 3'd0, 32'h0}) begin
      errors++;
      $display("FAIL reset32: got %h expected %h", act32, {1'b1, 1'b0, 2'd0, 3'd0, 32'h0});
    end
    tick(1'b1, 16'h401F, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 16'h501F, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 16'hC080, 1'b1, 1'b0, 1'b0);
    checks++;
    if (act16 !== {1'b1, 1'b0, 2'd0, 3'd0, 16'h0}) begin
      errors++;
      $display("FAIL reset_midstream: got %h expected %h", act16, {1'b1, 1'b0, 2'd0, 3'd0, 16'h0});
    end
  endtask

  task automatic test_formats();
    logic [15:0] words [6] = '{16'h401F, 16'h501F, 16'hC080, 16'h9080, 16'h2400, 16'hD800};
    logic [15:0] e16   [6] = '{16'hFFFF, 16'h001F, 16'hFF80, 16'h0080, 16'hFC00, 16'h0000};
    logic [31:0] e32   [6] = '{32'hFFFFFFFF, 32'h0000001F, 32'hFFFFFF80, 32'h00000080,
                               32'hFFFFFC00, 32'h00000000};
    logic [2:0]  ef    [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, words[i], 1'b1, 1'b0, 1'b1);
      checks++;
      if ({out_valid16, fmt16, imm16} !== {1'b1, ef[i], e16[i]}) begin
        errors++;
        $display("FAIL fmt16[%h]: got v=%b fmt=%0d imm=%h expected v=1 fmt=%0d imm=%h",
                 words[i], out_valid16, fmt16, imm16, ef[i], e16[i]);
      end
      checks++;
      if ({fmt32, imm32} !== {ef[i], e32[i]}) begin
        errors++;
        $display("FAIL fmt32[%h]: got fmt=%0d imm=%h expected fmt=%0d imm=%h",
                 words[i], fmt32, imm32, ef[i], e32[i]);
      end
    end
    tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({out_valid16, count16, fmt16, imm16} !== {1'b0, 2'd0, 3'd0, 16'h0}) begin
      errors++;
      $display("FAIL drain_empty: got v=%b cnt=%0d fmt=%0d imm=%h expected all zero",
               out_valid16, count16, fmt16, imm16);
    end
  endtask

  task automatic test_full();
    tick(1'b1, 16'h401F, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 16'h501F, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({count16, in_ready16, imm16} !== {2'd2, 1'b0, 16'hFFFF}) begin
      errors++;
      $display("FAIL full: got cnt=%0d rdy=%b imm=%h expected cnt=2 rdy=0 imm=ffff",
               count16, in_ready16, imm16);
    end
    tick(1'b1, 16'hC080, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({count16, in_ready16, imm16} !== {2'd2, 1'b0, 16'hFFFF}) begin
      errors++;
      $display("FAIL held_off: got cnt=%0d rdy=%b imm=%h expected cnt=2 rdy=0 imm=ffff",
               count16, in_ready16, imm16);
    end
    tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({count16, in_ready16, fmt16, imm16} !== {2'd1, 1'b1, 3'd2, 16'h001F}) begin
      errors++;
      $display("FAIL pop1: got cnt=%0d rdy=%b fmt=%0d imm=%h expected cnt=1 rdy=1 fmt=2 imm=001f",
               count16, in_ready16, fmt16, imm16);
    end
    tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({count16, out_valid16} !== {2'd0, 1'b0}) begin
      errors++;
      $display("FAIL pop2: got cnt=%0d v=%b expected cnt=0 v=0", count16, out_valid16);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    ent_t        e;
    tick(1'b1, 16'h401F, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      e = ref_decode(w);
      tick(1'b1, w, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({count16, out_valid16, fmt16, imm16, imm32} !== {2'd1, 1'b1, e.fmt, e.imm[15:0], e.imm}) begin
        errors++;
        $display("FAIL b2b[%0d] w=%h: got cnt=%0d fmt=%0d imm16=%h imm32=%h expected cnt=1 fmt=%0d imm=%h",
                 i, w, count16, fmt16, imm16, imm32, e.fmt, e.imm);
      end
    end
    tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    tick(1'b1, 16'h401F, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 16'h501F, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 16'hC080, 1'b0, 1'b1, 1'b1);
    checks++;
    if (act16 !== {1'b1, 1'b0, 2'd0, 3'd0, 16'h0}) begin
      errors++;
      $display("FAIL flush_full: got %h expected %h", act16, {1'b1, 1'b0, 2'd0, 3'd0, 16'h0});
    end
    tick(1'b1, 16'h401F, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 16'h2400, 1'b1, 1'b1, 1'b1);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({count16, out_valid16, imm16} !== {2'd0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL flush_push_lost: got cnt=%0d v=%b imm=%h expected cnt=0 v=0 imm=0000",
               count16, out_valid16, imm16);
    end
    tick(1'b1, 16'h9080, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({count16, fmt16, imm32} !== {2'd1, 3'd4, 32'h00000080}) begin
      errors++;
      $display("FAIL after_flush: got cnt=%0d fmt=%0d imm32=%h expected cnt=1 fmt=4 imm32=00000080",
               count16, fmt16, imm32);
    end
    tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic v, ordy, fl, rn;
    logic [15:0] w;
    for (int i = 0; i < 600; i++) begin
      v    = ($urandom % 4) != 0;
      w    = 16'($urandom);
      ordy = ($urandom % 3) != 0;
      fl   = ($urandom % 40) == 0;
      rn   = ($urandom % 60) != 0;
      tick(v, w, ordy, fl, rn);
      checks++;
      if (act16 !== exp16()) begin
        errors++;
        $display("FAIL rand16[%0d]: got %h expected %h", i, act16, exp16());
      end
      checks++;
      if (act32 !== exp32()) begin
        errors++;
        $display("FAIL rand32[%0d]: got %h expected %h", i, act32, exp32());
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    instr     = 16'h0;
    out_ready = 1'b0;
    test_reset();
    test_formats();
    test_full();
    test_back_to_back();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
